systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Operand feeder for the `pe_array` systolic matrix-multiply grid. It stores one SIZE×SIZE matrix A and one SIZE×SIZE matrix B, loaded one row at a time. On `start`, it drives them into the array's left-column and top-row inputs with the diagonal skew the array needs, so that the grid accumulates C = A×B. It then holds zeros for a drain window and pulses `done`.

## Interface
- `SIZE`, default 4: array dimension; must be ≥ 2.
- `DW`, default 8: operand width, signed two's complement.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  write one matrix row; accepted only when `wr_ready` = 1.
- `wr_sel`  in  1  0 selects matrix A, 1 selects matrix B.
- `wr_row`  in  $clog2(SIZE)  row index; values ≥ SIZE are ignored (no write).
- `wr_data`  in  SIZE*DW  one row; element k is at `[DW*k+DW-1:DW*k]`.
- `wr_ready`  out  1  high in IDLE only.
- `start`  in  1  begin streaming; accepted only in IDLE.
- `busy`  out  1  high in FEED, DRAIN and DONE.
- `a_out`  out  SIZE*DW  lane i drives array row i (left edge `a_in[i]`).
- `b_out`  out  SIZE*DW  lane j drives array column j (top edge `b_in[j]`).
- `feed_valid`  out  1  high during FEED cycles.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
- Storage: `A[r][k]` = `wr_data` element k when `wr_sel` = 0; `B[r][c]` = `wr_data` element c when `wr_sel` = 1. Contents persist across runs. Reset clears all contents to 0.
- States:
  - IDLE: `wr_ready` = 1; writes are allowed; `start` moves to FEED with t = 0.
  - FEED: lasts 2*SIZE-1 cycles, t = 0..2*SIZE-2; moves to DRAIN after t = 2*SIZE-2.
  - DRAIN: lasts SIZE cycles; all lanes drive 0.
  - DONE: 1 cycle, `done` = 1; returns to IDLE.
- Skew in FEED at step t:
  - a_out lane i = A[i][t-i] if 0 ≤ t-i < SIZE, else 0.
  - b_out lane j = B[t-j][j] if 0 ≤ t-j < SIZE, else 0.
- Outside FEED, `a_out` and `b_out` are 0.
- Arithmetic: none. Operands pass through unchanged; zero-fill is the value 0.
- The array has no clear input. Clearing accumulators between runs is the system's job, by reset. The feeder does not modify accumulated results.
- `wr_en` outside IDLE is ignored; storage is unchanged.
- `start` outside IDLE is ignored; it is not queued.
- `wr_en` and `start` in the same IDLE cycle: the write commits and the start is accepted. The first FEED step reads the updated storage.
- Writing the same row twice keeps the last write.

## Timing
- All outputs are registered.
- Reset values: `a_out` = 0, `b_out` = 0, `feed_valid` = 0, `done` = 0, `busy` = 0, `wr_ready` = 1; state IDLE.
- `start` sampled at edge E0 → FEED t = 0 is visible in the cycle after E0. FEED occupies cycles 1..2*SIZE-1 after E0.
- `done` is high in cycle 3*SIZE after E0 (SIZE = 4: cycle 12). `wr_ready` rises in cycle 3*SIZE+1.
- A new `start` is accepted in the first IDLE cycle after `done`, with no dead cycles beyond that.
- Reset asserted in any state: outputs go to reset values immediately (asynchronous). After release the block is in IDLE with empty storage and no `done` pulse.
- Written data is readable by a run starting on the next edge.

## Test plan
- Reset: hold `rst_n` = 0 for 3 cycles, then release → `a_out` = 0, `b_out` = 0, `busy` = 0, `done` = 0, `wr_ready` = 1.
- Skew trace, SIZE = 4: load A[r][k] = 10r+k and B[r][c] = 100+10r+c, then start → at t = 0, a_out = {0,0,0,0} with lane0 = 0 and b_out lane0 = 100, other lanes 0. At t = 3, a_out lanes = {3,12,21,30} and b_out lanes = {130,121,112,103}. At t = 6, only lane 3 is nonzero: A = 33, B = 133. `done` at cycle 12.
- Integration with `pe_array`: A = identity, B arbitrary signed values, start, wait for `done` → `c_out` equals B elementwise. Repeat with A = B = all -128 → every `c_out` = 65536.
- Ignored requests: `start` and `wr_en` (row 0 of A set to all 7) asserted during FEED → no restart, `done` still at cycle 12. A replay shows the original row 0.
- Reset during FEED at t = 3 → outputs are 0 in the same cycle. After release, `busy` = 0, no `done`, and a replay streams zeros (storage cleared).
- Back-to-back runs: `start` held high continuously → runs begin at E0 and again in cycle 3*SIZE+1, each producing exactly one `done`. A simultaneous write and start in IDLE → the first FEED step uses the new data.

Source files
------------

// File: rtl/systolic_feeder_if.sv
//------------------------------------------------------------------
// systolic_feeder_if: row-load, control and operand lanes of the feeder
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

interface systolic_feeder_if #(
  parameter int SIZE = 4,
  parameter int DW   = 8
);
  localparam int RW = $clog2(SIZE);

  logic               wr_en;
  logic               wr_sel;
  logic [RW-1:0]      wr_row;
  logic [SIZE*DW-1:0] wr_data;
  logic               wr_ready;
  logic               start;
  logic               busy;
  logic [SIZE*DW-1:0] a_out;
  logic [SIZE*DW-1:0] b_out;
  logic               feed_valid;
  logic               done;

  modport master (
    output wr_en, wr_sel, wr_row, wr_data, start,
    input  wr_ready, busy, a_out, b_out, feed_valid, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_data, start,
    output wr_ready, busy, a_out, b_out, feed_valid, done
  );
endinterface

`default_nettype wire

// File: rtl/systolic_feeder.sv
//------------------------------------------------------------------
// systolic_feeder: stores A and B, streams them diagonally skewed into pe_array
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module systolic_feeder #(
  parameter int SIZE = 4,
  parameter int DW   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  systolic_feeder_if.slave bus
);
  localparam int RW = $clog2(SIZE);
  localparam int TW = $clog2(2*SIZE);
  localparam logic [RW:0] ROW_LIMIT = (RW+1)'(SIZE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [TW-1:0]      t, t_nxt;
  logic [DW-1:0]      mem_a [SIZE][SIZE];
  logic [DW-1:0]      mem_b [SIZE][SIZE];
  logic [DW-1:0]      a_eff [SIZE][SIZE];
  logic [DW-1:0]      b_eff [SIZE][SIZE];
  logic [SIZE*DW-1:0] a_nxt, b_nxt;
  logic [SIZE*DW-1:0] a_out_r, b_out_r;
  logic               feed_valid_r, done_r, busy_r, wr_ready_r;
  logic               wr_ok, wr_a, wr_b;

  assign wr_ok = (state == S_IDLE) && bus.wr_en && ({1'b0, bus.wr_row} < ROW_LIMIT);
  assign wr_a  = wr_ok && !bus.wr_sel;
  assign wr_b  = wr_ok &&  bus.wr_sel;

  // Storage after this cycle's write, so a start in the same cycle sees new data.
  always_comb begin
    for (int r = 0; r < SIZE; r++) begin
      for (int k = 0; k < SIZE; k++) begin
        a_eff[r][k] = (wr_a && bus.wr_row == RW'(r)) ? bus.wr_data[DW*k +: DW] : mem_a[r][k];
        b_eff[r][k] = (wr_b && bus.wr_row == RW'(r)) ? bus.wr_data[DW*k +: DW] : mem_b[r][k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a <= '{default: '0};
      mem_b <= '{default: '0};
    end else begin
      mem_a <= a_eff;
      mem_b <= b_eff;
    end
  end

  // t counts FEED steps, then is reused as the DRAIN cycle counter.
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_FEED;
          t_nxt     = '0;
        end
      end
      S_FEED: begin
        if (t == TW'(2*SIZE-2)) begin
          state_nxt = S_DRAIN;
          t_nxt     = '0;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      S_DRAIN: begin
        if (t == TW'(SIZE-1)) begin
          state_nxt = S_DONE;
          t_nxt     = '0;
        end else begin
          t_nxt = t + TW'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Lane i carries A[i][t-i]; lane j carries B[t-j][j]; zero off the diagonal band.
  always_comb begin
    a_nxt = '0;
    b_nxt = '0;
    if (state_nxt == S_FEED) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int k = 0; k < SIZE; k++) begin
          if (int'(t_nxt) == i + k) begin
            a_nxt[DW*i +: DW] = a_eff[i][k];
            b_nxt[DW*i +: DW] = b_eff[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      t            <= '0;
      a_out_r      <= '0;
      b_out_r      <= '0;
      feed_valid_r <= 1'b0;
      done_r       <= 1'b0;
      busy_r       <= 1'b0;
      wr_ready_r   <= 1'b1;
    end else begin
      state        <= state_nxt;
      t            <= t_nxt;
      a_out_r      <= a_nxt;
      b_out_r      <= b_nxt;
      feed_valid_r <= (state_nxt == S_FEED);
      done_r       <= (state_nxt == S_DONE);
      busy_r       <= (state_nxt != S_IDLE);
      wr_ready_r   <= (state_nxt == S_IDLE);
    end
  end

  assign bus.a_out      = a_out_r;
  assign bus.b_out      = b_out_r;
  assign bus.feed_valid = feed_valid_r;
  assign bus.done       = done_r;
  assign bus.busy       = busy_r;
  assign bus.wr_ready   = wr_ready_r;

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
//------------------------------------------------------------------
// tb_systolic_feeder: randomized checks of systolic_feeder against a matrix model
// Rev 1.0
//------------------------------------------------------------------
`default_nettype none

module tb_systolic_feeder;
  localparam int S  = 4;
  localparam int DW = 8;
  localparam int NSTEP = 2*S-1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  int ma [S][S];
  int mb [S][S];
  int a_hist [NSTEP][S];
  int b_hist [NSTEP][S];
  int c_fed  [S][S];

  systolic_feeder_if #(.SIZE(S), .DW(DW)) bus ();

  systolic_feeder #(.SIZE(S), .DW(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic int sx(input int x);
    logic [DW-1:0] b;
    b = x[DW-1:0];
    return int'($signed(b));
  endfunction

  function automatic int lane(input logic [S*DW-1:0] v, input int i);
    logic [S*DW-1:0] tmp;
    tmp = v >> (i*DW);
    return int'($signed(tmp[DW-1:0]));
  endfunction

  function automatic logic [S*DW-1:0] pack(input int v[S]);
    logic [S*DW-1:0] p;
    int x;
    p = '0;
    for (int k = 0; k < S; k++) begin
      x = v[k];
      p[k*DW +: DW] = x[DW-1:0];
    end
    return p;
  endfunction

  function automatic int exp_a(input int t, input int i);
    if (t - i >= 0 && t - i < S) return ma[i][t-i];
    return 0;
  endfunction

  function automatic int exp_b(input int t, input int j);
    if (t - j >= 0 && t - j < S) return mb[t-j][j];
    return 0;
  endfunction

  function automatic int hist_a(input int s, input int i);
    if (s >= 0 && s < NSTEP) return a_hist[s][i];
    return 0;
  endfunction

  function automatic int hist_b(input int s, input int j);
    if (s >= 0 && s < NSTEP) return b_hist[s][j];
    return 0;
  endfunction

  function automatic int model_c(input int i, input int j);
    int acc = 0;
    for (int k = 0; k < S; k++) acc += ma[i][k] * mb[k][j];
    return acc;
  endfunction

  task automatic write_row(input bit sel, input int row, input int v[S]);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_row  = row[$clog2(S)-1:0];
    bus.wr_data = pack(v);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    for (int k = 0; k < S; k++) begin
      if (sel) mb[row][k] = sx(v[k]);
      else     ma[row][k] = sx(v[k]);
    end
  endtask

  task automatic load_random();
    int v[S];
    for (int r = 0; r < S; r++) begin
      for (int k = 0; k < S; k++) v[k] = int'($urandom_range(0, 255)) - 128;
      write_row(1'b0, r, v);
      for (int k = 0; k < S; k++) v[k] = int'($urandom_range(0, 255)) - 128;
      write_row(1'b1, r, v);
    end
  endtask

  // Starts a run (plus any write already driven), checks every output cycle by cycle
  // and rebuilds what each PE(i,j) of the grid would accumulate from the streams.
  task automatic run_stream(input string tag, input int inject);
    bit feed;
    int t, ea, eb, aa, ab, acc;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    for (int c = 1; c <= 3*S+1; c++) begin
      @(negedge clk);
      feed = (c <= 2*S-1);
      t = c - 1;
      checks++;
      if (bus.feed_valid !== feed) begin
        errors++;
        $display("FAIL %s feed_valid cyc=%0d got=%b want=%b", tag, c, bus.feed_valid, feed);
      end
      checks++;
      if (bus.busy !== (c <= 3*S)) begin
        errors++;
        $display("FAIL %s busy cyc=%0d got=%b want=%b", tag, c, bus.busy, c <= 3*S);
      end
      checks++;
      if (bus.done !== (c == 3*S)) begin
        errors++;
        $display("FAIL %s done cyc=%0d got=%b want=%b", tag, c, bus.done, c == 3*S);
      end
      checks++;
      if (bus.wr_ready !== (c == 3*S+1)) begin
        errors++;
        $display("FAIL %s wr_ready cyc=%0d got=%b want=%b", tag, c, bus.wr_ready, c == 3*S+1);
      end
      for (int i = 0; i < S; i++) begin
        ea = feed ? exp_a(t, i) : 0;
        eb = feed ? exp_b(t, i) : 0;
        aa = lane(bus.a_out, i);
        ab = lane(bus.b_out, i);
        if (feed) begin
          a_hist[t][i] = aa;
          b_hist[t][i] = ab;
        end
        checks++;
        if (aa !== ea) begin
          errors++;
          $display("FAIL %s a_out lane%0d cyc=%0d got=%0d want=%0d", tag, i, c, aa, ea);
        end
        checks++;
        if (ab !== eb) begin
          errors++;
          $display("FAIL %s b_out lane%0d cyc=%0d got=%0d want=%0d", tag, i, c, ab, eb);
        end
      end
      if (c == inject) begin
        bus.start   = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_row  = '0;
        bus.wr_data = {S{8'd7}};
      end else if (c == inject + 1) begin
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
      end
    end
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) begin
        acc = 0;
        for (int tau = 0; tau < 3*S; tau++) acc += hist_a(tau - j, i) * hist_b(tau - i, j);
        c_fed[i][j] = acc;
      end
    end
  endtask

  task automatic test_reset();
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_data = '0; bus.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < S; r++) for (int k = 0; k < S; k++) begin ma[r][k] = 0; mb[r][k] = 0; end
    @(negedge clk);
    checks++;
    if (bus.a_out !== '0 || bus.b_out !== '0) begin
      errors++;
      $display("FAIL reset lanes got a=%h b=%h want 0", bus.a_out, bus.b_out);
    end
    checks++;
    if ({bus.busy, bus.done, bus.feed_valid, bus.wr_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset flags got busy/done/fv/rdy=%b want 0001",
               {bus.busy, bus.done, bus.feed_valid, bus.wr_ready});
    end
  endtask

  task automatic test_skew_trace();
    int v[S];
    int wa3[S], wb3[S];
    for (int r = 0; r < S; r++) begin
      for (int k = 0; k < S; k++) v[k] = 10*r + k;
      write_row(1'b0, r, v);
      for (int k = 0; k < S; k++) v[k] = 100 + 10*r + k;
      write_row(1'b1, r, v);
    end
    run_stream("skew", -1);
    wa3 = '{3, 12, 21, 30};
    wb3 = '{130, 121, 112, 103};
    for (int i = 0; i < S; i++) begin
      checks++;
      if ((a_hist[3][i] & 255) !== wa3[i] || (b_hist[3][i] & 255) !== wb3[i]) begin
        errors++;
        $display("FAIL skew_t3 lane%0d got a=%0d b=%0d want a=%0d b=%0d",
                 i, a_hist[3][i] & 255, b_hist[3][i] & 255, wa3[i], wb3[i]);
      end
    end
    checks++;
    if ((a_hist[6][3] & 255) !== 33 || (b_hist[6][3] & 255) !== 133 || (b_hist[0][0] & 255) !== 100) begin
      errors++;
      $display("FAIL skew_corners got a6=%0d b6=%0d b0=%0d want 33 133 100",
               a_hist[6][3] & 255, b_hist[6][3] & 255, b_hist[0][0] & 255);
    end
  endtask

  task automatic test_integration();
    int v[S];
    for (int r = 0; r < S; r++) begin
      for (int k = 0; k < S; k++) v[k] = (r == k) ? 1 : 0;
      write_row(1'b0, r, v);
      for (int k = 0; k < S; k++) v[k] = int'($urandom_range(0, 255)) - 128;
      write_row(1'b1, r, v);
    end
    run_stream("ident", -1);
    for (int i = 0; i < S; i++) for (int j = 0; j < S; j++) begin
      checks++;
      if (c_fed[i][j] !== mb[i][j]) begin
        errors++;
        $display("FAIL ident c[%0d][%0d] got=%0d want=%0d", i, j, c_fed[i][j], mb[i][j]);
      end
    end
    for (int k = 0; k < S; k++) v[k] = -128;
    for (int r = 0; r < S; r++) begin
      write_row(1'b0, r, v);
      write_row(1'b1, r, v);
    end
    run_stream("neg128", -1);
    for (int i = 0; i < S; i++) for (int j = 0; j < S; j++) begin
      checks++;
      if (c_fed[i][j] !== 65536) begin
        errors++;
        $display("FAIL neg128 c[%0d][%0d] got=%0d want=65536", i, j, c_fed[i][j]);
      end
    end
  endtask

  task automatic test_random_runs();
    int v[S];
    for (int n = 0; n < 4; n++) begin
      load_random();
      for (int k = 0; k < S; k++) v[k] = int'($urandom_range(0, 255)) - 128;
      write_row(1'b1, 1, v);
      for (int k = 0; k < S; k++) v[k] = int'($urandom_range(0, 255)) - 128;
      write_row(1'b1, 1, v);
      run_stream("random", -1);
      for (int i = 0; i < S; i++) for (int j = 0; j < S; j++) begin
        checks++;
        if (c_fed[i][j] !== model_c(i, j)) begin
          errors++;
          $display("FAIL random c[%0d][%0d] got=%0d want=%0d", i, j, c_fed[i][j], model_c(i, j));
        end
      end
    end
  endtask

  task automatic test_ignored();
    load_random();
    run_stream("ignored", 3);
    run_stream("replay", -1);
  endtask

  task automatic test_reset_mid_feed();
    load_random();
    ma[0][3] = 55; mb[3][0] = 55;
    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = '0;
    bus.wr_data = pack('{ma[0][0], ma[0][1], ma[0][2], 55});
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (lane(bus.a_out, 0) !== 55) begin
      errors++;
      $display("FAIL rst_pre a_out lane0 got=%0d want=55", lane(bus.a_out, 0));
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.a_out !== '0 || bus.b_out !== '0 ||
        {bus.busy, bus.done, bus.feed_valid, bus.wr_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL rst_async got a=%h b=%h flags=%b want 0 0 0001", bus.a_out, bus.b_out,
               {bus.busy, bus.done, bus.feed_valid, bus.wr_ready});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < S; r++) for (int k = 0; k < S; k++) begin ma[r][k] = 0; mb[r][k] = 0; end
    for (int c = 0; c < 3*S+2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_after cyc=%0d got done=%b busy=%b want 0 0", c, bus.done, bus.busy);
      end
    end
    run_stream("rst_replay", -1);
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int v[S];
    load_random();
    bus.start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 6*S+2; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
      if (c == 1 || c == 3*S+1 || c == 3*S+2) begin
        checks++;
        if (bus.feed_valid !== (c != 3*S+1)) begin
          errors++;
          $display("FAIL b2b feed_valid cyc=%0d got=%b want=%b", c, bus.feed_valid, c != 3*S+1);
        end
      end
      if (c == 3*S+2) begin
        checks++;
        if (lane(bus.a_out, 0) !== ma[0][0] || lane(bus.b_out, 0) !== mb[0][0]) begin
          errors++;
          $display("FAIL b2b second_t0 got a=%0d b=%0d want a=%0d b=%0d",
                   lane(bus.a_out, 0), lane(bus.b_out, 0), ma[0][0], mb[0][0]);
        end
      end
      if (c == 6*S+2) bus.start = 1'b0;
    end
    checks++;
    if (dones !== 2) begin
      errors++;
      $display("FAIL b2b done_count got=%0d want=2", dones);
    end
    @(negedge clk);
    checks++;
    if (bus.wr_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b idle got rdy=%b busy=%b want 1 0", bus.wr_ready, bus.busy);
    end
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < S; k++) v[k] = int'($urandom_range(0, 255)) - 128;
      bus.wr_en   = 1'b1;
      bus.wr_sel  = s[0];
      bus.wr_row  = '0;
      bus.wr_data = pack(v);
      for (int k = 0; k < S; k++) begin
        if (s == 0) ma[0][k] = sx(v[k]);
        else        mb[0][k] = sx(v[k]);
      end
      run_stream("wr_start", -1);
    end
  endtask

  initial begin
    test_reset();
    test_skew_trace();
    test_integration();
    test_random_runs();
    test_ignored();
    test_reset_mid_feed();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
